// File: rtl/booth_pkg.sv
// Shared types, control codes and decode helpers for the Booth multiplier controller.
package booth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    OP,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB
  } op_t;

  // Adder control codes, ordered {ctl_add, ctl_sub, ctl_init}
  localparam logic [2:0] CTL_ADD  = 3'b100;
  localparam logic [2:0] CTL_SUB  = 3'b110;
  localparam logic [2:0] CTL_INIT = 3'b001;
  localparam logic [2:0] CTL_NONE = 3'b000;

  // Radix-2 Booth recoding of the {Q[0], Q_1} pair
  function automatic op_t booth_op(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b10:   return OP_SUB;
      2'b01:   return OP_ADD;
      default: return OP_NONE;
    endcase
  endfunction

  function automatic logic [2:0] ctl_code(input op_t op);
    case (op)
      OP_ADD:  return CTL_ADD;
      OP_SUB:  return CTL_SUB;
      default: return CTL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/booth_ctrl_if.sv
// Request/result and adder-facing signals of booth_ctrl; slave = controller, master = user + adder.
interface booth_ctrl_if #(
  parameter int unsigned REG_WIDTH = 8
) ();

  localparam int unsigned PROD_W = 2 * REG_WIDTH;

  logic                 start;
  logic [REG_WIDTH-1:0] multiplicand;
  logic [REG_WIDTH-1:0] multiplier;
  logic                 busy;
  logic                 result_valid;
  logic [PROD_W-1:0]    product;
  logic [REG_WIDTH-1:0] add_a;
  logic [REG_WIDTH-1:0] add_b;
  logic [REG_WIDTH-1:0] add_result;
  logic                 ctl_add;
  logic                 ctl_sub;
  logic                 ctl_init;

  modport slave (
    input  start, multiplicand, multiplier, add_result,
    output busy, result_valid, product, add_a, add_b, ctl_add, ctl_sub, ctl_init
  );

  modport master (
    output start, multiplicand, multiplier, add_result,
    input  busy, result_valid, product, add_a, add_b, ctl_add, ctl_sub, ctl_init
  );

endinterface

// File: rtl/booth_shift_reg.sv
// {A, Q, Q_1} working register of the Booth multiplier with load, clear-A and arithmetic shift.
module booth_shift_reg #(
  parameter int unsigned REG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear_a,
  input  logic                 shift,
  input  logic [REG_WIDTH-1:0] load_q,
  input  logic [REG_WIDTH-1:0] a_new,
  input  logic                 a_sign,
  output logic [REG_WIDTH-1:0] a,
  output logic [REG_WIDTH-1:0] q,
  output logic                 q_1,
  output logic [REG_WIDTH-1:0] a_sh_c,
  output logic [REG_WIDTH-1:0] q_sh_c,
  output logic                 q_1_sh_c
);

  // a_sign is the true sign of the partial sum, which shifts into A's MSB
  assign a_sh_c   = {a_sign, a_new[REG_WIDTH-1:1]};
  assign q_sh_c   = {a_new[0], q[REG_WIDTH-1:1]};
  assign q_1_sh_c = q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      a   <= '0;
      q   <= '0;
      q_1 <= 1'b0;
    end else if (load) begin
      q   <= load_q;
      q_1 <= 1'b0;
    end else if (clear_a) begin
      a   <= '0;
    end else if (shift) begin
      a   <= a_sh_c;
      q   <= q_sh_c;
      q_1 <= q_1_sh_c;
    end
  end

endmodule

// File: rtl/booth_ctrl.sv
// Booth radix-2 sequential multiplier controller driving an external add/sub unit.
// Optional BOOTH_SKIP_NOP_EN: no-op iterations shift inside OP and skip the SHIFT state.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int unsigned REG_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  booth_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(REG_WIDTH + 1);
  localparam int unsigned MSB   = REG_WIDTH - 1;

  state_t                 state;
  op_t                    op_r;
  logic [REG_WIDTH-1:0]   m;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             ctl;
  logic                   busy_r;
  logic                   valid_r;
  logic [2*REG_WIDTH-1:0] product_r;

  logic [REG_WIDTH-1:0]   a;
  logic [REG_WIDTH-1:0]   q;
  logic                   q_1;
  logic [REG_WIDTH-1:0]   a_sh_c;
  logic [REG_WIDTH-1:0]   q_sh_c;
  logic                   q_1_sh_c;

  op_t                    cur_op_c;
  op_t                    nxt_op_c;
  logic [REG_WIDTH-1:0]   a_new_c;
  logic                   a_sign_c;
  logic                   ovf_c;
  logic                   skip_c;
  logic                   shift_c;
  logic                   load_c;
  logic                   clear_a_c;
  logic                   last_c;

  assign cur_op_c  = booth_op(q[0], q_1);
  assign nxt_op_c  = booth_op(q_sh_c[0], q_1_sh_c);
  assign load_c    = (state == IDLE) && bus.start;
  assign clear_a_c = (state == INIT);
  assign last_c    = (cnt == CNT_W'(1));

`ifdef BOOTH_SKIP_NOP_EN
  assign skip_c = (state == OP) && (cur_op_c == OP_NONE);
`else
  assign skip_c = 1'b0;
`endif

  assign shift_c = (state == SHIFT) || skip_c;

  // Partial-sum select; the sign bit is overflow-corrected so -2^(W-1) operands stay exact
  always_comb begin
    a_new_c  = a;
    a_sign_c = a[MSB];
    ovf_c    = 1'b0;
    if ((state == SHIFT) && (op_r != OP_NONE)) begin
      a_new_c = bus.add_result;
      if (op_r == OP_ADD) begin
        ovf_c = (a[MSB] == m[MSB]) && (bus.add_result[MSB] != a[MSB]);
      end else begin
        ovf_c = (a[MSB] != m[MSB]) && (bus.add_result[MSB] != a[MSB]);
      end
      a_sign_c = bus.add_result[MSB] ^ ovf_c;
    end
  end

  booth_shift_reg #(
    .REG_WIDTH (REG_WIDTH)
  ) u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .clear_a  (clear_a_c),
    .shift    (shift_c),
    .load_q   (bus.multiplier),
    .a_new    (a_new_c),
    .a_sign   (a_sign_c),
    .a        (a),
    .q        (q),
    .q_1      (q_1),
    .a_sh_c   (a_sh_c),
    .q_sh_c   (q_sh_c),
    .q_1_sh_c (q_1_sh_c)
  );

  // Sequencer; controls are registered so each code is stable for a whole cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_r      <= OP_NONE;
      m         <= '0;
      cnt       <= '0;
      ctl       <= CTL_NONE;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      product_r <= '0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            m      <= bus.multiplicand;
            cnt    <= CNT_W'(REG_WIDTH);
            ctl    <= CTL_INIT;
            busy_r <= 1'b1;
            state  <= INIT;
          end
        end
        INIT: begin
          ctl   <= ctl_code(cur_op_c);
          state <= OP;
        end
        OP: begin
          op_r <= cur_op_c;
          ctl  <= CTL_NONE;
          if (skip_c) begin
            cnt <= cnt - CNT_W'(1);
            if (last_c) begin
              product_r <= {a_sh_c, q_sh_c};
              valid_r   <= 1'b1;
              state     <= DONE;
            end else begin
              ctl <= ctl_code(nxt_op_c);
            end
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          cnt <= cnt - CNT_W'(1);
          if (last_c) begin
            product_r <= {a_sh_c, q_sh_c};
            valid_r   <= 1'b1;
            state     <= DONE;
          end else begin
            ctl   <= ctl_code(nxt_op_c);
            state <= OP;
          end
        end
        DONE: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.result_valid = valid_r;
  assign bus.product      = product_r;
  assign bus.add_a        = a;
  assign bus.add_b        = m;
  assign {bus.ctl_add, bus.ctl_sub, bus.ctl_init} = ctl;

endmodule

// File: tb/tb_booth_ctrl.sv
// Scoreboard bench for booth_ctrl with a behavioural add/sub unit that re-evaluates on control change.
module tb_booth_ctrl;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [15:0] prod;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic        prev_v = 1'b0;
  logic [2:0]  prev_ctl = 3'b000;
  logic [2:0]  ctl_now;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_ctrl_if #(.REG_WIDTH(W)) bif ();

  booth_ctrl #(.REG_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  assign ctl_now = {bif.ctl_add, bif.ctl_sub, bif.ctl_init};

  // Adder model: output changes only when the control code changes
  always @(negedge clk) begin
    if (rst) begin
      bif.add_result <= '0;
      prev_ctl       <= 3'b000;
    end else if (ctl_now != prev_ctl) begin
      prev_ctl <= ctl_now;
      case (ctl_now)
        3'b100:  bif.add_result <= bif.add_a + bif.add_b;
        3'b110:  bif.add_result <= bif.add_a - bif.add_b;
        3'b001:  bif.add_result <= '0;
        default: bif.add_result <= bif.add_result;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int unsigned lat(input logic [W-1:0] q);
`ifdef BOOTH_SKIP_NOP_EN
    int unsigned l = 1;
    logic        p = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      l += (q[i] != p) ? 32'd2 : 32'd1;
      p = q[i];
    end
    return l;
`else
    return 2 * W + 1;
`endif
  endfunction

  function automatic logic [15:0] ref_prod(input logic [W-1:0] m, input logic [W-1:0] q);
    logic signed [15:0] sm;
    logic signed [15:0] sq;
    sm = {{8{m[W-1]}}, m};
    sq = {{8{q[W-1]}}, q};
    return 16'(sm * sq);
  endfunction

  // Monitor: pops the scoreboard on every result_valid
  always @(negedge clk) begin
    if (!rst) begin
      chk("ctl_legal", 32'((ctl_now == 3'b000) || (ctl_now == 3'b100) ||
                           (ctl_now == 3'b110) || (ctl_now == 3'b001)), 32'd1);
      if (bif.result_valid) begin
        chk("valid_pulse", 32'(prev_v), 32'd0);
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got result_valid with product 0x%0h, required none", bif.product);
        end else begin
          mon_e = sbq.pop_front();
          chk("product", 32'(bif.product), 32'(mon_e.prod));
          chk("latency", cyc, mon_e.cyc);
        end
      end
    end
    prev_v <= bif.result_valid;
  end

  task automatic wait_idle();
    int g = 0;
    while (bif.busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (bif.busy) chk("idle_timeout", 32'(bif.busy), 32'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"},  32'(bif.busy), 32'd0);
    chk({nm, "_valid"}, 32'(bif.result_valid), 32'd0);
    chk({nm, "_prod"},  32'(bif.product), 32'd0);
    chk({nm, "_ctl"},   32'(ctl_now), 32'd0);
    chk({nm, "_add_a"}, 32'(bif.add_a), 32'd0);
    chk({nm, "_add_b"}, 32'(bif.add_b), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge k
  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q, input logic [15:0] p,
                       output int unsigned k, output int unsigned l);
    wait_idle();
    bif.multiplicand = m;
    bif.multiplier   = q;
    bif.start        = 1'b1;
    k = cyc + 1;
    l = lat(q);
    sbq.push_back(exp_t'{prod: p, cyc: 32'(k + l)});
    @(negedge clk);
    bif.start = 1'b0;
  endtask

  task automatic run(input logic [W-1:0] m, input logic [W-1:0] q, input logic [15:0] p);
    int unsigned k;
    int unsigned l;
    issue(m, q, p, k, l);
  endtask

  task automatic run_watch(input logic [W-1:0] m, input logic [W-1:0] q, input logic [15:0] p,
                           input bit check_seq);
    int unsigned k;
    int unsigned l;
    logic [2:0]  seq_tbl [9] = '{3'b001, 3'b110, 3'b000, 3'b100, 3'b000,
                                 3'b110, 3'b000, 3'b100, 3'b000};
    issue(m, q, p, k, l);
    for (int n = 0; n <= int'(l); n++) begin
      if (n > 0) @(negedge clk);
      chk("busy_during_op", 32'(bif.busy), 32'd1);
      if (check_seq) chk("ctl_seq", 32'(ctl_now), (n < 9) ? 32'(seq_tbl[n]) : 32'd0);
    end
    @(negedge clk);
    chk("busy_after_done", 32'(bif.busy), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    int unsigned l1;
    int          g;
    logic [W-1:0] rm;
    logic [W-1:0] rq;

    bif.start        = 1'b0;
    bif.multiplicand = '0;
    bif.multiplier   = '0;
    rst              = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic signed multiply with per-cycle busy check
    run_watch(8'd3, 8'hFE, 16'hFFFA, 1'b0);

    // Most-negative operand corners
    run(8'h80, 8'h80, 16'h4000);
    run(8'h7F, 8'h80, 16'hC080);

    // Control-code sequence
    run_watch(8'd7, 8'd5, 16'h0023, 1'b1);

    // Synchronous reset in the middle of an operation
    wait_idle();
    bif.multiplicand = 8'd9;
    bif.multiplier   = 8'd9;
    bif.start        = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    bif.start = 1'b0;
    while (cyc < k + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midop_reset");
    rst = 1'b0;
    repeat (25) @(negedge clk);
    run(8'hFF, 8'd1, 16'hFFFF);

    // start held high across a whole operation
    wait_idle();
    bif.multiplicand = 8'd5;
    bif.multiplier   = 8'd6;
    bif.start        = 1'b1;
    k  = cyc + 1;
    l1 = lat(8'd6);
    sbq.push_back(exp_t'{prod: 16'h001E, cyc: 32'(k + l1)});
    @(negedge clk);
    bif.multiplicand = 8'hFD;
    bif.multiplier   = 8'd4;
    while (cyc < k + l1 + 1) @(negedge clk);
    chk("held_start_idle_busy", 32'(bif.busy), 32'd0);
    chk("held_start_idle_prod", 32'(bif.product), 32'h001E);
    sbq.push_back(exp_t'{prod: 16'hFFF4, cyc: 32'(k + l1 + 2 + lat(8'd4))});
    @(negedge clk);
    chk("held_start_reaccept", 32'(bif.busy), 32'd1);
    chk("held_start_prod_kept", 32'(bif.product), 32'h001E);
    bif.start = 1'b0;

    // Random signed pairs against the reference product
    for (int i = 0; i < 1000; i++) begin
      rm = 8'($urandom);
      rq = 8'($urandom);
      run(rm, rq, ref_prod(rm, rq));
    end

    g = 0;
    while (sbq.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_ctrl.md
Name: booth_ctrl

Overview:
Sequential control and datapath-register stage that drives the team's Booth combinational adder (control code {ctl_add,ctl_sub,ctl_init}).
- Holds accumulator A, multiplier Q, bit Q_1 and iteration counter.
- Feeds A and the multiplicand M to the adder, captures the adder result, performs the arithmetic shift and presents the signed 2*REG_WIDTH-bit product.
- Sits directly upstream of the adder and also consumes its output.

Parameters:
REG_WIDTH, 8, operand width in bits; must be >= 2; product is 2*REG_WIDTH.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE
multiplicand  input  REG_WIDTH  signed M; captured when start is accepted
multiplier  input  REG_WIDTH  signed Q; captured when start is accepted
busy  output  1  high in every state except IDLE
result_valid  output  1  one-cycle pulse in DONE
product  output  2*REG_WIDTH  signed {A,Q}; held until next start is accepted
add_a  output  REG_WIDTH  to adder input_a; always equals A
add_b  output  REG_WIDTH  to adder input_b; always equals M
add_result  input  REG_WIDTH  from adder output_c
ctl_add  output  1  adder control
ctl_sub  output  1  adder control
ctl_init  output  1  adder control

Behaviour:
- Reset: state IDLE; A, Q, M, Q_1, counter, product = 0; busy = 0; result_valid = 0; controls = 000.
- Reset mid-operation: same result on the next edge; the operation is discarded and no result_valid is produced.
- Control codes {add,sub,init}:
  - ADD = 100
  - SUB = 110 (both add and sub high)
  - INIT = 001
  - NONE = 000
- Only these codes are ever driven.
- IDLE: on start=1, capture M and Q, set Q_1 = 0 and counter = REG_WIDTH, then go to INIT. When start=0, stay in IDLE.
- INIT (1 cycle): drive INIT; set A = 0 directly (do not rely on add_result); go to OP.
- OP (1 cycle): select the code from {Q[0],Q_1}:
  - 10 -> SUB
  - 01 -> ADD
  - 00 or 11 -> NONE
  - Register the chosen op internally; go to SHIFT.
- SHIFT (1 cycle): drive NONE.
  - If the op was ADD or SUB, the new A is add_result; otherwise it is the old A.
  - Arithmetic-shift-right {newA,Q,Q_1} by one: A MSB replicates; A LSB moves to Q MSB; Q LSB moves to Q_1.
  - Decrement counter. If the counter was 1, go to DONE; otherwise go to OP.
- Control edge rule: SHIFT always drives NONE, so every ADD/SUB is preceded by a control transition. This is required because the adder re-evaluates only on a control change.
- DONE (1 cycle): product = {A,Q}; result_valid = 1; go to IDLE.
- Latency (feature off): result_valid is visible 2*REG_WIDTH+1 rising edges after the edge that samples start (17 for REG_WIDTH=8). Next start is accepted in the cycle after DONE.
- start while busy: ignored; no queuing.
- Arithmetic: all register operations are two's complement and modulo REG_WIDTH. The full product is exact for all inputs, including -2^(REG_WIDTH-1) squared.

Optional Feature:
BOOTH_SKIP_NOP_EN
- Defined: in OP, if {Q[0],Q_1} is 00 or 11, perform the SHIFT action in that same cycle and skip the SHIFT state; controls stay NONE. Latency becomes 2 + (#ADD/SUB iterations)*2 + (#NOP iterations) - 1 edges.
- Undefined: fixed latency as in Behaviour.

Decomposition:
- Package booth_pkg:
  - state enum {IDLE, INIT, OP, SHIFT, DONE}
  - localparams CTL_ADD=3'b100, CTL_SUB=3'b110, CTL_INIT=3'b001, CTL_NONE=3'b000
  - op enum {OP_NONE, OP_ADD, OP_SUB}
- Sub-module booth_shift_reg: holds {A,Q,Q_1}, with load, clear and arithmetic-shift controls. The FSM and counter stay in booth_ctrl.
- Bench connects booth_ctrl to the existing adder with REG_WIDTH matched.

Test Plan:
1. Reset, then M=3, Q=-2 (0xFE), start pulse -> result_valid exactly 17 edges later; product=0xFFFA (-6); busy high throughout.
2. M=-128, Q=-128 -> product=0x4000; M=127, Q=-128 -> product=0xC080.
3. M=7, Q=5 -> product=0x0023. Check the control sequence SUB, ADD, SUB, ADD, then NONE for the remaining OP cycles, with NONE in every SHIFT. With BOOTH_SKIP_NOP_EN, result_valid arrives 13 edges after start.
4. Start M=9, Q=9; assert rst for one cycle at edge 6 -> next cycle IDLE, all outputs 0, no result_valid. Then M=-1, Q=1 -> product=0xFFFF.
5. start held high through an operation -> second multiply begins only from IDLE after DONE. product holds the first result until the second start is accepted.
6. Random signed pairs (1000+), both with and without BOOTH_SKIP_NOP_EN -> product equals the signed reference product; result_valid is a single-cycle pulse.
